// File: rtl/rv_memory.sv
// Dual-port (data + instruction fetch) word memory with byte-lane stores,
// a fixed response latency of READ_LAT cycles, and full pipelining on both ports.
module rv_memory #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W+1:0] d_addr,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic              d_err,
  input  logic              i_req,
  input  logic [ADDR_W+1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_valid,
  output logic              i_err
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  if ((READ_LAT != 1) && (READ_LAT != 2)) begin : gen_lat_check
    $error("rv_memory: READ_LAT must be 1 or 2");
  end

  // Raw word is carried down the pipe; lane selection happens at the output.
  typedef struct packed {
    logic        v;
    logic        err;
    logic        ld;
    logic [1:0]  off;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] word;
  } dstage_t;

  typedef struct packed {
    logic        v;
    logic        err;
    logic [31:0] word;
  } istage_t;

  logic [31:0] mem [Depth];

  logic              d_mis;
  logic              i_mis;
  logic [ADDR_W-1:0] d_idx;
  logic [ADDR_W-1:0] i_idx;
  logic [3:0]        be;
  logic [31:0]       wdata_al;
  logic              d_wr;
  dstage_t           d_new;
  istage_t           i_new;
  dstage_t           d_pipe_q [READ_LAT];
  istage_t           i_pipe_q [READ_LAT];
  dstage_t           d_last;
  istage_t           i_last;
  logic [7:0]        sel_b;
  logic [15:0]       sel_h;

  assign d_idx = d_addr[ADDR_W+1:2];
  assign i_idx = i_addr[ADDR_W+1:2];

  // Request decode: misalignment, byte enables and lane-replicated store data.
  always_comb begin
    d_mis    = (d_size == 2'b11) ||
               ((d_size == 2'b01) && d_addr[0]) ||
               ((d_size == 2'b10) && (d_addr[1:0] != 2'b00));
    i_mis    = (i_addr[1:0] != 2'b00);
    be       = 4'b0000;
    wdata_al = d_wdata;
    unique case (d_size)
      2'b00: begin
        be       = 4'b0001 << d_addr[1:0];
        wdata_al = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        be       = d_addr[1] ? 4'b1100 : 4'b0011;
        wdata_al = {2{d_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    // Requests seen while in reset are dropped, including their stores.
    d_wr = d_req && d_we && !d_mis && !rst;
  end

  // Array write; contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (d_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[d_idx][8*b +: 8] <= wdata_al[8*b +: 8];
      end
    end
  end

  // New pipe entries sample the array before this edge's write (read-before-write).
  always_comb begin
    d_new      = '0;
    d_new.v    = d_req;
    d_new.err  = d_mis;
    d_new.ld   = !d_we && !d_mis;
    d_new.off  = d_addr[1:0];
    d_new.size = d_size;
    d_new.uns  = d_unsigned;
    d_new.word = mem[d_idx];
    i_new      = '0;
    i_new.v    = i_req;
    i_new.err  = i_mis;
    i_new.word = mem[i_idx];
  end

  // Response pipeline; reset flushes everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < READ_LAT; k++) begin
        d_pipe_q[k] <= '0;
        i_pipe_q[k] <= '0;
      end
    end else begin
      d_pipe_q[0] <= d_new;
      i_pipe_q[0] <= i_new;
      for (int k = 1; k < READ_LAT; k++) begin
        d_pipe_q[k] <= d_pipe_q[k-1];
        i_pipe_q[k] <= i_pipe_q[k-1];
      end
    end
  end

  assign d_last = d_pipe_q[READ_LAT-1];
  assign i_last = i_pipe_q[READ_LAT-1];
  assign sel_b  = d_last.word[{d_last.off, 3'b000} +: 8];
  assign sel_h  = d_last.off[1] ? d_last.word[31:16] : d_last.word[15:0];

  // Output stage: lane select and extension; gated by rst so reset clears outputs at once.
  always_comb begin
    d_ack   = 1'b0;
    d_err   = 1'b0;
    d_rdata = '0;
    i_valid = 1'b0;
    i_err   = 1'b0;
    i_rdata = '0;
    if (!rst && d_last.v) begin
      d_ack = 1'b1;
      d_err = d_last.err;
      if (d_last.ld) begin
        case (d_last.size)
          2'b00:   d_rdata = {{24{!d_last.uns && sel_b[7]}}, sel_b};
          2'b01:   d_rdata = {{16{!d_last.uns && sel_h[15]}}, sel_h};
          default: d_rdata = d_last.word;
        endcase
      end
    end
    if (!rst && i_last.v) begin
      i_valid = 1'b1;
      i_err   = i_last.err;
      if (!i_last.err) i_rdata = i_last.word;
    end
  end

endmodule
